// File: rtl/dm_bhw.sv
// Byte-addressable data memory for the MIPS MEM stage: sized loads/stores,
// fixed-latency registered responses, and a post-reset zeroing sweep.
module dm_bhw #(
    parameter int ADDR_SIZE   = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int RD_LATENCY  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    logic          state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [RD_LATENCY-1:0] pv_q;
    logic [RD_LATENCY-1:0] pe_q;
    logic [31:0]           pd_q [RD_LATENCY];

    logic          accept;
    logic          req_err;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_data;
    logic [31:0]   rsp_data_d;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          wr_en;
    logic          unused_addr_bits;

    // Address bits above the word index wrap silently.
    assign unused_addr_bits = ^req_addr[ADDR_SIZE-1:AW+2];

    assign busy      = (state_q == ST_CLEAR);
    assign req_ready = (state_q == ST_RUN);
    assign accept    = req_valid && req_ready;

    assign idx  = req_addr[AW+1:2];
    assign lane = req_addr[1:0];

    always_comb begin
        case (req_size)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = req_addr[0];
            2'd2:    req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Read uses the array before this edge's store, giving store-then-load order.
    assign rd_word  = mem_q[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};
    assign byte_v   = rd_shift[7:0];
    assign half_v   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (req_size)
            2'd0:    load_data = {{24{~req_unsigned & byte_v[7]}}, byte_v};
            2'd1:    load_data = {{16{~req_unsigned & half_v[15]}}, half_v};
            2'd2:    load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    assign rsp_data_d = (req_we || req_err) ? '0 : load_data;

    always_comb begin
        be = '0;
        wd = req_wdata;
        case (req_size)
            2'd0: begin
                be = 4'b0001 << lane;
                wd = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be = req_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                be = 4'b1111;
                wd = req_wdata;
            end
            default: begin
                be = '0;
                wd = req_wdata;
            end
        endcase
    end

    assign wr_en = accept && req_we && !req_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
            pe_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) pd_q[i] <= '0;
        end else begin
            pv_q[0] <= accept;
            pe_q[0] <= accept && req_err;
            pd_q[0] <= accept ? rsp_data_d : '0;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign rsp_valid = pv_q[RD_LATENCY-1];
    assign rsp_err   = pe_q[RD_LATENCY-1];
    assign rsp_rdata = pd_q[RD_LATENCY-1];

endmodule

// File: tb/tb_dm_bhw.sv
// Directed bench: drives identical requests into a latency-1 and a latency-3
// instance of dm_bhw and checks both against hand-computed results.
module tb_dm_bhw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        rdy1, rv1, er1, bz1;
    logic [31:0] rd1;
    logic        rdy3, rv3, er3, bz3;
    logic [31:0] rd3;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t pv [6];

    always #5 clk = ~clk;

    dm_bhw #(.ADDR_SIZE(32), .DEPTH_WORDS(16), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1),
        .rsp_rdata(rd1), .rsp_err(er1), .busy(bz1)
    );

    dm_bhw #(.ADDR_SIZE(32), .DEPTH_WORDS(16), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv3),
        .rsp_rdata(rd3), .rsp_err(er3), .busy(bz3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    // Single request, then check the latency-1 and latency-3 responses.
    task automatic req1(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
        drive(we, sz, uns, addr, wd);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, ".v1"}, {31'd0, rv1}, 32'd1);
        chk({tag, ".d1"}, rd1, exp_d);
        chk({tag, ".e1"}, {31'd0, er1}, {31'd0, exp_e});
        chk({tag, ".v3early"}, {31'd0, rv3}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ".v1off"}, {31'd0, rv1}, 32'd0);
        chk({tag, ".v3mid"}, {31'd0, rv3}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ".v3"}, {31'd0, rv3}, 32'd1);
        chk({tag, ".d3"}, rd3, exp_d);
        chk({tag, ".e3"}, {31'd0, er3}, {31'd0, exp_e});
    endtask

    // Hold reset 3 cycles, check reset values, then time the clear sweep while
    // a store is offered that must be ignored.
    task automatic do_reset();
        int n;
        int bad;
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", {30'd0, bz1, bz3}, 32'd3);
        chk("rst.ready", {30'd0, rdy1, rdy3}, 32'd0);
        chk("rst.valid", {30'd0, rv1, rv3}, 32'd0);
        chk("rst.err", {30'd0, er1, er3}, 32'd0);
        chk("rst.rdata1", rd1, 32'd0);
        chk("rst.rdata3", rd3, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF);
        n = 0;
        bad = 0;
        while (bz1 && n < 100) begin
            if (rdy1 || rdy3 || rv1 || rv3 || (bz3 !== bz1)) bad++;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        chk("clear.cycles", n, 32'd16);
        chk("clear.quiet", bad, 32'd0);
        chk("clear.ready", {30'd0, rdy1, rdy3}, 32'd3);
    endtask

    initial begin
        pv[0] = '{1'b1, 2'd2, 1'b0, 32'h30, 32'h01020304, 32'h0,        1'b0};
        pv[1] = '{1'b0, 2'd2, 1'b0, 32'h30, 32'h0,        32'h01020304, 1'b0};
        pv[2] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hBEEFAA44, 1'b0};
        pv[3] = '{1'b0, 2'd0, 1'b1, 32'h33, 32'h0,        32'h00000001, 1'b0};
        pv[4] = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFFBEEF, 1'b0};
        pv[5] = '{1'b0, 2'd2, 1'b0, 32'h22, 32'h0,        32'h0,        1'b1};

        do_reset();
        req1("clr_lw0",  1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
        req1("clr_lw3c", 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);

        req1("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0);
        req1("sb11", 1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFAA, 32'h0, 1'b0);
        req1("sh12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h1234BEEF, 32'h0, 1'b0);
        req1("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hBEEFAA44, 1'b0);

        req1("sw00",  1'b1, 2'd2, 1'b0, 32'h00, 32'h80FF7F01, 32'h0, 1'b0);
        req1("lb3",   1'b0, 2'd0, 1'b0, 32'h03, 32'h0, 32'hFFFFFF80, 1'b0);
        req1("lbu3",  1'b0, 2'd0, 1'b1, 32'h03, 32'h0, 32'h00000080, 1'b0);
        req1("lh2",   1'b0, 2'd1, 1'b0, 32'h02, 32'h0, 32'hFFFF80FF, 1'b0);
        req1("lhu2",  1'b0, 2'd1, 1'b1, 32'h02, 32'h0, 32'h000080FF, 1'b0);
        req1("lb1",   1'b0, 2'd0, 1'b0, 32'h01, 32'h0, 32'h0000007F, 1'b0);
        req1("lh0",   1'b0, 2'd1, 1'b0, 32'h00, 32'h0, 32'h00007F01, 1'b0);
        req1("lwuns", 1'b0, 2'd2, 1'b1, 32'h00, 32'h0, 32'h80FF7F01, 1'b0);

        req1("sw20",   1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        req1("sh21",   1'b1, 2'd1, 1'b0, 32'h21, 32'h00001111, 32'h0, 1'b1);
        req1("sw22",   1'b1, 2'd2, 1'b0, 32'h22, 32'h22222222, 32'h0, 1'b1);
        req1("sz3_20", 1'b1, 2'd3, 1'b0, 32'h20, 32'h33333333, 32'h0, 1'b1);
        req1("lh23",   1'b0, 2'd1, 1'b0, 32'h23, 32'h0, 32'h0, 1'b1);
        req1("lw20",   1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

        req1("sw40",   1'b1, 2'd2, 1'b0, 32'h40, 32'h5A5A5A5A, 32'h0, 1'b0);
        req1("lw0wr",  1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'h5A5A5A5A, 1'b0);
        req1("lwhigh", 1'b0, 2'd2, 1'b0, 32'hFFFF0000, 32'h0, 32'h5A5A5A5A, 1'b0);

        // Back-to-back burst: latency-1 answers each cycle, latency-3 two cycles later.
        for (int k = 0; k < 9; k++) begin
            if (k < 6) drive(pv[k].we, pv[k].sz, pv[k].uns, pv[k].addr, pv[k].wd);
            else req_valid = 1'b0;
            @(posedge clk); #1;
            if (k < 6) begin
                chk($sformatf("pipe1.v%0d", k), {31'd0, rv1}, 32'd1);
                chk($sformatf("pipe1.d%0d", k), rd1, pv[k].exp);
                chk($sformatf("pipe1.e%0d", k), {31'd0, er1}, {31'd0, pv[k].err});
            end else begin
                chk($sformatf("pipe1.idle%0d", k), {31'd0, rv1}, 32'd0);
            end
            if (k >= 2 && k < 8) begin
                chk($sformatf("pipe3.v%0d", k-2), {31'd0, rv3}, 32'd1);
                chk($sformatf("pipe3.d%0d", k-2), rd3, pv[k-2].exp);
                chk($sformatf("pipe3.e%0d", k-2), {31'd0, er3}, {31'd0, pv[k-2].err});
            end else begin
                chk($sformatf("pipe3.idle%0d", k), {31'd0, rv3}, 32'd0);
            end
        end

        // Two loads in flight in the latency-3 instance when reset hits.
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid.v1pre", {31'd0, rv1}, 32'd1);
        chk("mid.v3pre", {31'd0, rv3}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid.vasync", {30'd0, rv1, rv3}, 32'd0);
        chk("mid.busy", {30'd0, bz1, bz3}, 32'd3);
        do_reset();
        req1("post_lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        req1("post_lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_bhw.md
# dm_bhw

Parametrised, byte-addressable data memory for the pipelined MIPS core's MEM stage. It replaces the word-only, negedge-write data memory. It supports:
- byte, halfword and word loads and stores, with sign/zero extension;
- a pipelined valid/ready request path with a fixed, parametrised response latency;
- misalignment detection;
- a post-reset clear sweep that zeroes the whole array before accepting traffic.

## Interface
Parameters:
- ADDR_SIZE, 32, byte-address width.
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..4096.
- RD_LATENCY, 1, cycles from request acceptance to response; legal 1..4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_SIZE  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, extended; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or illegal-size; qualified by rsp_valid.
- busy  output  1  clear sweep in progress.

## Operation
- **Word index:** req_addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- **Byte lanes:** little-endian. Byte lane = addr[1:0], occupying bits [8*lane+7 : 8*lane]. Half lane = addr[1], occupying bits [16*addr[1]+15 : 16*addr[1]].
- **Alignment checks:**
  - Half requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - size 3 is always illegal.
  - An erroring request writes nothing and returns rsp_err = 1 with rsp_rdata = 0.
- **Stores:** modify only the addressed lanes; other lanes of the word are preserved.
- **Loads:** extract the addressed lane and extend per req_unsigned. Word loads ignore req_unsigned.
- **Responses:** every accepted request, load or store, produces exactly one response, in acceptance order. There is no response backpressure.
- **Accept condition:** req_valid && req_ready. req_ready = !busy. One request per cycle is accepted when ready.
- **FSM, two states:**
  - CLEAR: busy = 1, req_ready = 0. The sweep counter writes 0 to word index cnt each cycle, cnt runs 0 -> DEPTH_WORDS-1. After the write at cnt = DEPTH_WORDS-1, go to RUN.
  - RUN: busy = 0, req_ready = 1. Stays in RUN until rst.
- **Reset mid-operation:** in-flight responses are discarded; the FSM returns to CLEAR with cnt = 0; memory contents are cleared again.
- req_valid during CLEAR is ignored, with no side effects.

## Timing
- **Reset values** (asynchronous, while rst = 1):
  - state = CLEAR, cnt = 0, busy = 1, req_ready = 0;
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
  - all latency-pipeline valid bits = 0.
- **Clear sweep:** the first sweep write occurs on the first rising edge after rst deasserts. busy falls after exactly DEPTH_WORDS edges.
- **Acceptance at edge N:**
  - A store's array write commits at edge N.
  - A load's array read samples state as of edge N, i.e. it includes all stores accepted at edges < N.
- **Response timing:** rsp_valid, rsp_rdata and rsp_err are registered and asserted in the cycle after edge N+RD_LATENCY-1 (RD_LATENCY = 1: visible the cycle immediately after acceptance). They are held for exactly one cycle unless another response follows.
- **Store-to-load:** a store accepted at N followed by a load to the same address at N+1 returns the new data. No forwarding is needed beyond this ordering.
- **Throughput:** back-to-back requests yield back-to-back rsp_valid pulses.

## Test plan
- **Reset/clear:** assert rst for 3 cycles, release -> busy = 1 for exactly DEPTH_WORDS cycles, req_ready = 0 throughout, then any word load returns 0x00000000, rsp_err = 0.
- **Store widths:** sw 0x11223344 @0x10, then sb 0xAA @0x11, then sh 0xBEEF @0x12 -> lw @0x10 returns 0xBEEFAA44.
- **Load extension:**
  - From word 0x80FF7F01: lb @0x3 returns 0xFFFFFF80 and lbu @0x3 returns 0x00000080.
  - lh @0x2 returns 0xFFFF80FF and lhu @0x2 returns 0x000080FF.
- **Misalignment:** sh @0x21, sw @0x22 and size = 3 @0x20 -> each gives rsp_err = 1, rsp_rdata = 0, and the word at 0x20 is unchanged afterwards.
- **Pipelining, RD_LATENCY = 3:** sw then lw to the same address on consecutive cycles, followed by 4 more loads -> 6 responses in order, each 3 cycles after its request, and the first lw returns the stored value.
- **Wrap and reset mid-flight:**
  - sw 0x5A5A5A5A @4*DEPTH_WORDS reads back via lw @0x0.
  - Asserting rst with 2 responses in flight -> no rsp_valid after reset, and a full clear sweep restarts.
